// File: rtl/crc32_8023_wide.sv
// crc32_8023_wide
//   IEEE 802.3 CRC-32 engine for the GMII MAC datapath, DW-bit beats.
//   Folds data beats into the CRC (with a partial last beat), then emits
//   the FCS in DW-bit beats. It also flags the good-frame residue for RX
//   FCS checking.
// Parameters
//   DW        data width, 8/16/32 (BN = DW/8 bytes per beat)
// Ports
//   clk       rising-edge clock
//   reset_n   async active-low reset
//   load_init preset CRC to all ones, start a frame (drops a coincident beat)
//   d_valid   beat qualifier
//   calc      1: fold d into the CRC, 0: emit FCS bytes
//   d         data, byte 0 on d[7:0], bit 0 of each byte first on wire
//   d_bytes   valid bytes in a calc beat (1..BN); other values are a no-op
//   crc_reg   current CRC register, non-reflected
//   crc       registered FCS beat, FCS byte k on lane k
//   crc_valid crc carries FCS bytes this cycle
//   emit_done pulse with the beat carrying the 4th FCS byte
//   crc_ok    crc_reg equals the good-frame residue
module crc32_8023_wide #(
  parameter int DW = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load_init,
  input  logic                      d_valid,
  input  logic                      calc,
  input  logic [DW-1:0]             d,
  input  logic [$clog2(DW/8+1)-1:0] d_bytes,
  output logic [31:0]               crc_reg,
  output logic [DW-1:0]             crc,
  output logic                      crc_valid,
  output logic                      emit_done,
  output logic                      crc_ok
);
  localparam int          BN      = DW / 8;
  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

  state_t        state_q;
  logic [31:0]   crc_reg_q, fold_d, shift_d;
  logic [DW-1:0] crc_q, emit_d;
  logic          crc_valid_q, emit_done_q;
  logic [2:0]    emit_cnt_q, n_emit, cnt_d;
  logic          bytes_ok;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign bytes_ok = (d_bytes != '0) && (int'(d_bytes) <= BN);

  // Bit-serial fold, lane 0 first, LSB of each byte first.
  always_comb begin
    fold_d = crc_reg_q;
    for (int b = 0; b < BN; b++) begin
      if (b < int'(d_bytes)) begin
        for (int i = 0; i < 8; i++) begin
          if (fold_d[31] ^ d[8*b+i]) fold_d = {fold_d[30:0], 1'b0} ^ POLY;
          else                       fold_d = {fold_d[30:0], 1'b0};
        end
      end
    end
  end

  // crc_reg is shifted left as bytes go out, so the next FCS byte always
  // sits in crc_reg[31:24]; lane k takes byte k of the current register,
  // which is FCS byte emit_cnt+k of the original value.
  always_comb begin
    n_emit  = ((3'd4 - emit_cnt_q) < 3'(BN)) ? (3'd4 - emit_cnt_q) : 3'(BN);
    emit_d  = '0;
    shift_d = crc_reg_q;
    for (int k = 0; k < BN; k++) begin
      if (k < int'(n_emit)) begin
        emit_d[8*k +: 8] = ~bitrev8(crc_reg_q[31-8*k -: 8]);
        shift_d          = {shift_d[23:0], 8'hFF};
      end
    end
    cnt_d = emit_cnt_q + n_emit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      crc_reg_q   <= 32'hFFFF_FFFF;
      crc_q       <= '0;
      crc_valid_q <= 1'b0;
      emit_done_q <= 1'b0;
      emit_cnt_q  <= 3'd0;
    end else if (load_init) begin
      state_q     <= CALC;
      crc_reg_q   <= 32'hFFFF_FFFF;
      crc_valid_q <= 1'b0;
      emit_done_q <= 1'b0;
      emit_cnt_q  <= 3'd0;
    end else if (d_valid && calc) begin
      crc_valid_q <= 1'b0;
      emit_done_q <= 1'b0;
      // Data arriving after emission started is ignored until re-init.
      if (state_q != EMIT && bytes_ok) begin
        crc_reg_q <= fold_d;
        state_q   <= CALC;
      end
    end else if (d_valid) begin
      // With all 4 bytes out n_emit is 0: crc clears, crc_reg holds.
      state_q     <= EMIT;
      crc_q       <= emit_d;
      crc_reg_q   <= shift_d;
      emit_cnt_q  <= cnt_d;
      crc_valid_q <= (n_emit != 3'd0);
      emit_done_q <= (n_emit != 3'd0) && (cnt_d == 3'd4);
    end else begin
      crc_valid_q <= 1'b0;
      emit_done_q <= 1'b0;
    end
  end

  assign crc_reg   = crc_reg_q;
  assign crc       = crc_q;
  assign crc_valid = crc_valid_q;
  assign emit_done = emit_done_q;
  assign crc_ok    = (crc_reg_q == RESIDUE);

endmodule
